// File: rtl/gpmc_pkg.sv
// Shared definitions for the GPMC target bridge: FSM encoding, defaults and well-known
// register addresses.
package gpmc_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_WRITE,
      ST_RD_WAIT,
      ST_RD_DATA
   } state_t;

   localparam logic [15:0] TIMEOUT_DATA_DEF = 16'hDEAD;

   // Read-wait timer width; READ_WAIT is limited to 1..7.
   localparam int RD_TMR_W = 3;

   localparam logic [14:0] ID_ADDR      = 15'h0000;
   localparam logic [14:0] SCRATCH_ADDR = 15'h0001;

endpackage

// File: rtl/gpmc_target_bridge_if.sv
// Pin-side (GPMC) and internal-bus signals of the bridge. The bridge connects to modport
// slave; whoever plays host plus register file connects to modport master.
interface gpmc_target_bridge_if #(
   parameter int ADDR_W = 15,
   parameter int CNT_W  = 8
);
   logic [15:0]       gpmc_ad_in;
   logic [15:0]       gpmc_ad_out;
   logic              gpmc_ad_oe;
   logic              gpmc_advn;
   logic              gpmc_csn;
   logic              gpmc_wein;
   logic              gpmc_oen;
   logic [ADDR_W-1:0] bus_addr;
   logic              bus_wr_en;
   logic [15:0]       bus_wr_data;
   logic              bus_rd_en;
   logic [15:0]       bus_rd_data;
   logic              bus_rd_valid;
   logic [CNT_W-1:0]  rd_timeout_cnt;

   modport slave (
      input  gpmc_ad_in, gpmc_advn, gpmc_csn, gpmc_wein, gpmc_oen,
             bus_rd_data, bus_rd_valid,
      output gpmc_ad_out, gpmc_ad_oe, bus_addr, bus_wr_en, bus_wr_data, bus_rd_en,
             rd_timeout_cnt
   );

   modport master (
      output gpmc_ad_in, gpmc_advn, gpmc_csn, gpmc_wein, gpmc_oen,
             bus_rd_data, bus_rd_valid,
      input  gpmc_ad_out, gpmc_ad_oe, bus_addr, bus_wr_en, bus_wr_data, bus_rd_en,
             rd_timeout_cnt
   );
endinterface

// File: rtl/gpmc_rd_timer.sv
// Read-latency timer: loaded with READ_WAIT when a read is issued, counts down while the
// FSM waits, and flags expiry on the last permitted edge. Cleared whenever not running.
module gpmc_rd_timer
   import gpmc_pkg::*;
#(
   parameter int READ_WAIT = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic run,
   output logic expire
);

   logic [RD_TMR_W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)               cnt <= '0;
      else if (load)         cnt <= RD_TMR_W'(READ_WAIT);
      else if (!run)         cnt <= '0;
      else if (cnt != '0)    cnt <= cnt - 1'b1;
   end

   assign expire = run && (cnt == RD_TMR_W'(1));

endmodule

// File: rtl/gpmc_target_bridge.sv
// GPMC synchronous muxed A/D target: turns host cycles into one-cycle internal bus strobes
// with a bounded read latency. Define GPMC_BURST_EN for auto-incrementing write bursts.
module gpmc_target_bridge
   import gpmc_pkg::*;
#(
   parameter int          ADDR_W       = 15,
   parameter int          READ_WAIT    = 3,
   parameter logic [15:0] TIMEOUT_DATA = TIMEOUT_DATA_DEF,
   parameter int          CNT_W        = 8
) (
   input  logic               gpmc_clk,
   input  logic               reset,
   gpmc_target_bridge_if.slave gpmc
);

   state_t            state, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              wr_en_q, wr_en_d;
   logic [15:0]       wr_data_q, wr_data_d;
   logic              rd_en_q, rd_en_d;
   logic [15:0]       ad_out_q, ad_out_d;
   logic              ad_oe_q, ad_oe_d;
   logic [CNT_W-1:0]  to_cnt_q, to_cnt_d;
   logic              rd_start, rd_expire;

   gpmc_rd_timer #(.READ_WAIT(READ_WAIT)) u_rd_timer (
      .clk    (gpmc_clk),
      .rst    (reset),
      .load   (rd_start),
      .run    (state == ST_RD_WAIT),
      .expire (rd_expire)
   );

   always_ff @(posedge gpmc_clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         addr_q    <= '0;
         wr_en_q   <= 1'b0;
         wr_data_q <= '0;
         rd_en_q   <= 1'b0;
         ad_out_q  <= '0;
         ad_oe_q   <= 1'b0;
         to_cnt_q  <= '0;
      end else begin
         state     <= state_d;
         addr_q    <= addr_d;
         wr_en_q   <= wr_en_d;
         wr_data_q <= wr_data_d;
         rd_en_q   <= rd_en_d;
         ad_out_q  <= ad_out_d;
         ad_oe_q   <= ad_oe_d;
         to_cnt_q  <= to_cnt_d;
      end
   end

   always_comb begin
      state_d   = state;
      addr_d    = addr_q;
      wr_en_d   = 1'b0;
      wr_data_d = wr_data_q;
      rd_en_d   = 1'b0;
      ad_out_d  = ad_out_q;
      to_cnt_d  = to_cnt_q;
      rd_start  = 1'b0;
      // Chip-select release dominates every state and abandons any pending read.
      if (gpmc.gpmc_csn) begin
         state_d = ST_IDLE;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (!gpmc.gpmc_advn) begin
                  state_d = ST_ADDR;
                  addr_d  = gpmc.gpmc_ad_in[ADDR_W:1];
               end
            end
            ST_ADDR: begin
               if (!gpmc.gpmc_advn) begin
                  addr_d = gpmc.gpmc_ad_in[ADDR_W:1];
               end else if (!gpmc.gpmc_wein) begin
                  state_d   = ST_WRITE;
                  wr_en_d   = 1'b1;
                  wr_data_d = gpmc.gpmc_ad_in;
               end else if (!gpmc.gpmc_oen) begin
                  state_d  = ST_RD_WAIT;
                  rd_en_d  = 1'b1;
                  rd_start = 1'b1;
               end
            end
            ST_WRITE: begin
`ifdef GPMC_BURST_EN
               if (!gpmc.gpmc_wein) begin
                  wr_en_d   = 1'b1;
                  wr_data_d = gpmc.gpmc_ad_in;
                  addr_d    = addr_q + 1'b1;
               end
`else
               state_d = ST_WRITE;
`endif
            end
            ST_RD_WAIT: begin
               if (gpmc.bus_rd_valid) begin
                  state_d  = ST_RD_DATA;
                  ad_out_d = gpmc.bus_rd_data;
               end else if (rd_expire) begin
                  state_d  = ST_RD_DATA;
                  ad_out_d = TIMEOUT_DATA;
                  to_cnt_d = (to_cnt_q == '1) ? to_cnt_q : to_cnt_q + 1'b1;
               end
            end
            ST_RD_DATA: state_d = ST_RD_DATA;
            default:    state_d = ST_IDLE;
         endcase
      end
      ad_oe_d = (state_d == ST_RD_DATA) && !gpmc.gpmc_oen;
   end

   assign gpmc.gpmc_ad_out    = ad_out_q;
   assign gpmc.gpmc_ad_oe     = ad_oe_q;
   assign gpmc.bus_addr       = addr_q;
   assign gpmc.bus_wr_en      = wr_en_q;
   assign gpmc.bus_wr_data    = wr_data_q;
   assign gpmc.bus_rd_en      = rd_en_q;
   assign gpmc.rd_timeout_cnt = to_cnt_q;

endmodule

// File: tb/tb_gpmc_target_bridge.sv
// Directed bench for gpmc_target_bridge: host cycles drive expected writes/reads into
// scoreboard queues; a bus-side monitor and the host pop and compare them.
module tb_gpmc_target_bridge;

   localparam int ADDR_W = 15;
   localparam int RW     = 3;

   logic gpmc_clk = 1'b0;
   logic reset    = 1'b1;
   always #5 gpmc_clk = ~gpmc_clk;

   gpmc_target_bridge_if #(.ADDR_W(ADDR_W), .CNT_W(8)) bus_if ();

   gpmc_target_bridge #(
      .ADDR_W(ADDR_W), .READ_WAIT(RW), .TIMEOUT_DATA(16'hDEAD), .CNT_W(8)
   ) dut (
      .gpmc_clk (gpmc_clk),
      .reset    (reset),
      .gpmc     (bus_if.slave)
   );

   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] wr_q[$];
   logic [15:0] rd_q[$];
   logic [31:0] wexp;
   int          slave_lat = -1;
   logic [15:0] slave_word = 16'h0;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Bus-side write monitor: every strobe must match the next expected {addr,data}.
   always @(negedge gpmc_clk) begin
      if (bus_if.bus_wr_en === 1'b1) begin
         if (wr_q.size() == 0) begin
            chk("unexpected_write", {1'b0, bus_if.bus_addr, bus_if.bus_wr_data}, 32'hFFFF_FFFF);
         end else begin
            wexp = wr_q.pop_front();
            chk("write", {1'b0, bus_if.bus_addr, bus_if.bus_wr_data}, wexp);
         end
      end
   end

   // Register-file model: answers a read request slave_lat cycles later, or never if < 0.
   initial begin
      bus_if.bus_rd_valid = 1'b0;
      bus_if.bus_rd_data  = 16'h0;
      forever begin
         @(negedge gpmc_clk);
         if (bus_if.bus_rd_en === 1'b1 && slave_lat >= 0) begin
            repeat (slave_lat) @(negedge gpmc_clk);
            bus_if.bus_rd_valid = 1'b1;
            bus_if.bus_rd_data  = slave_word;
            @(negedge gpmc_clk);
            bus_if.bus_rd_valid = 1'b0;
            bus_if.bus_rd_data  = 16'h0;
         end
      end
   end

   task automatic addr_phase(logic [15:0] byte_addr);
      @(negedge gpmc_clk);
      bus_if.gpmc_csn   = 1'b0;
      bus_if.gpmc_advn  = 1'b0;
      bus_if.gpmc_wein  = 1'b1;
      bus_if.gpmc_oen   = 1'b1;
      bus_if.gpmc_ad_in = byte_addr;
   endtask

   task automatic release_cs();
      @(negedge gpmc_clk);
      bus_if.gpmc_csn   = 1'b1;
      bus_if.gpmc_advn  = 1'b1;
      bus_if.gpmc_wein  = 1'b1;
      bus_if.gpmc_oen   = 1'b1;
      bus_if.gpmc_ad_in = 16'h0;
   endtask

   task automatic push_wr(logic [15:0] byte_addr, int i, logic [15:0] d);
      logic [ADDR_W-1:0] a;
      a = ADDR_W'(byte_addr[ADDR_W:1] + i);
      wr_q.push_back({1'b0, a, d});
   endtask

   task automatic do_write(logic [15:0] byte_addr, int nwords, logic [15:0] d0);
      logic [15:0] d;
      addr_phase(byte_addr);
      for (int i = 0; i < nwords; i++) begin
         d = 16'(d0 + i);
         @(negedge gpmc_clk);
         bus_if.gpmc_advn  = 1'b1;
         bus_if.gpmc_wein  = 1'b0;
         bus_if.gpmc_ad_in = d;
`ifdef GPMC_BURST_EN
         push_wr(byte_addr, i, d);
`else
         if (i == 0) push_wr(byte_addr, 0, d);
`endif
      end
      release_cs();
      repeat (2) @(negedge gpmc_clk);
   endtask

   task automatic do_read(string tag, logic [15:0] byte_addr, int lat, logic [15:0] word,
                          logic [15:0] expw);
      logic [15:0] e;
      slave_lat  = lat;
      slave_word = word;
      rd_q.push_back(expw);
      addr_phase(byte_addr);
      @(negedge gpmc_clk);
      bus_if.gpmc_advn  = 1'b1;
      bus_if.gpmc_oen   = 1'b0;
      bus_if.gpmc_ad_in = 16'h0;
      repeat (RW + 2) @(negedge gpmc_clk);
      e = rd_q.pop_front();
      chk({tag, "_data"}, bus_if.gpmc_ad_out, e);
      chk({tag, "_oe"}, bus_if.gpmc_ad_oe, 1);
      chk({tag, "_addr"}, bus_if.bus_addr, byte_addr[ADDR_W:1]);
      repeat (3) @(negedge gpmc_clk);
      chk({tag, "_held"}, bus_if.gpmc_ad_out, e);
      release_cs();
      @(negedge gpmc_clk);
      chk({tag, "_oe_off"}, bus_if.gpmc_ad_oe, 0);
      slave_lat = -1;
   endtask

   initial begin
      logic oe_seen;
      bus_if.gpmc_csn   = 1'b1;
      bus_if.gpmc_advn  = 1'b1;
      bus_if.gpmc_wein  = 1'b1;
      bus_if.gpmc_oen   = 1'b1;
      bus_if.gpmc_ad_in = 16'h0;

      repeat (3) @(negedge gpmc_clk);
      chk("reset_outputs", {bus_if.gpmc_ad_out, 4'h0, bus_if.gpmc_ad_oe, bus_if.bus_wr_en,
                            bus_if.bus_rd_en, bus_if.bus_addr == '0}, 32'h0000_0001);
      chk("reset_cnt", bus_if.rd_timeout_cnt, 0);
      reset = 1'b0;
      @(negedge gpmc_clk);

      // 1: single write
      do_write(16'h0002, 1, 16'h4321);

      // 2: read with slave answering inside the window
      do_read("rd_ok", 16'h0000, 2, 16'hBEEF, 16'hBEEF);
      chk("rd_ok_cnt", bus_if.rd_timeout_cnt, 0);

      // 3: silent slave, then a late answer that must be ignored
      do_read("rd_to", 16'h0006, -1, 16'h0, 16'hDEAD);
      chk("rd_to_cnt", bus_if.rd_timeout_cnt, 1);
      do_read("rd_late", 16'h0008, 4, 16'h1234, 16'hDEAD);
      chk("rd_late_cnt", bus_if.rd_timeout_cnt, 2);
      do_read("rd_fast", 16'h000A, 0, 16'hC0DE, 16'hC0DE);

      // 4: CS dropped right after the read is issued; oen stays low throughout
      slave_lat = 2;
      slave_word = 16'h7777;
      addr_phase(16'h0010);
      @(negedge gpmc_clk);
      bus_if.gpmc_advn = 1'b1;
      bus_if.gpmc_oen  = 1'b0;
      @(negedge gpmc_clk);
      bus_if.gpmc_csn = 1'b1;
      oe_seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge gpmc_clk);
         oe_seen = oe_seen | (bus_if.gpmc_ad_oe !== 1'b0);
      end
      chk("abort_oe", oe_seen, 0);
      chk("abort_cnt", bus_if.rd_timeout_cnt, 2);
      bus_if.gpmc_oen = 1'b1;
      slave_lat = -1;
      do_write(16'h0020, 1, 16'h1111);

      // address re-latch: last address wins
      addr_phase(16'h0100);
      @(negedge gpmc_clk);
      bus_if.gpmc_ad_in = 16'h0200;
      @(negedge gpmc_clk);
      bus_if.gpmc_advn  = 1'b1;
      bus_if.gpmc_wein  = 1'b0;
      bus_if.gpmc_ad_in = 16'hA5A5;
      push_wr(16'h0200, 0, 16'hA5A5);
      release_cs();
      repeat (2) @(negedge gpmc_clk);

      // wein and oen both low: a write, bus never driven
      addr_phase(16'h0030);
      @(negedge gpmc_clk);
      bus_if.gpmc_advn  = 1'b1;
      bus_if.gpmc_wein  = 1'b0;
      bus_if.gpmc_oen   = 1'b0;
      bus_if.gpmc_ad_in = 16'h5A5A;
      push_wr(16'h0030, 0, 16'h5A5A);
      oe_seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge gpmc_clk);
         oe_seen = oe_seen | (bus_if.gpmc_ad_oe !== 1'b0);
      end
      chk("wr_rd_oe", oe_seen, 0);
      release_cs();
      repeat (2) @(negedge gpmc_clk);

      // advn with CS released: ignored
      @(negedge gpmc_clk);
      bus_if.gpmc_advn  = 1'b0;
      bus_if.gpmc_ad_in = 16'h0500;
      repeat (2) @(negedge gpmc_clk);
      bus_if.gpmc_advn = 1'b1;
      chk("advn_no_cs", bus_if.bus_addr, 15'h0018);

      // 5: burst (one write only when bursts are disabled) and address wrap
      do_write(16'h4000, 4, 16'h0100);
      do_write(16'hFFFE, 2, 16'h0F00);

      // 6: async reset while waiting for read data
      slave_lat = -1;
      addr_phase(16'h0004);
      @(negedge gpmc_clk);
      bus_if.gpmc_advn = 1'b1;
      bus_if.gpmc_oen  = 1'b0;
      @(negedge gpmc_clk);
      reset = 1'b1;
      #1;
      chk("rst_rd_en", bus_if.bus_rd_en, 0);
      chk("rst_mid", {bus_if.gpmc_ad_out, 8'h0, bus_if.rd_timeout_cnt},
          32'h0);
      chk("rst_addr", bus_if.bus_addr, 0);
      release_cs();
      reset = 1'b0;
      @(negedge gpmc_clk);
      do_read("rd_post_rst", 16'h0002, 1, 16'h5A5A, 16'h5A5A);
      chk("post_rst_cnt", bus_if.rd_timeout_cnt, 0);

      repeat (3) @(negedge gpmc_clk);
      chk("wr_q_empty", wr_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
